// File: rtl/warp_register_file.sv
// ---------------------------------------------------------------------------
// warp_register_file
//
// Banked SIMD register file: NUM_WARPS warp contexts x NUM_REGS registers x
// NUM_LANES lanes of DATA_W bits. One write port and two read ports, all
// with per-lane enables. After reset (or on init_req) the file sweeps every
// entry to zero, one entry per cycle, before it accepts accesses.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   init_req   in   re-clear the whole file (honoured only while ready)
//   ready      out  file accepts reads and writes
//   wr_warp    in   warp targeted by the write
//   write_en   in   per-lane write enable
//   waddr      in   write register address
//   wdata      in   write data, lane l at [l*DATA_W +: DATA_W]
//   rd_warp    in   warp targeted by both read ports
//   read_en_0  in   per-lane read enable, port 0
//   raddr_0    in   read register address, port 0
//   rdata_0    out  registered read data, port 0
//   rvalid_0   out  port 0 data valid
//   read_en_1 / raddr_1 / rdata_1 / rvalid_1: same for port 1
// ---------------------------------------------------------------------------
module warp_register_file #(
  parameter int NUM_LANES = 8,
  parameter int NUM_WARPS = 8,
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 64,
  localparam int WW = $clog2(NUM_WARPS),
  localparam int AW = $clog2(NUM_REGS),
  localparam int DW = NUM_LANES * DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_req,
  output logic                 ready,
  input  logic [WW-1:0]        wr_warp,
  input  logic [NUM_LANES-1:0] write_en,
  input  logic [AW-1:0]        waddr,
  input  logic [DW-1:0]        wdata,
  input  logic [WW-1:0]        rd_warp,
  input  logic [NUM_LANES-1:0] read_en_0,
  input  logic [NUM_LANES-1:0] read_en_1,
  input  logic [AW-1:0]        raddr_0,
  input  logic [AW-1:0]        raddr_1,
  output logic [DW-1:0]        rdata_0,
  output logic [DW-1:0]        rdata_1,
  output logic                 rvalid_0,
  output logic                 rvalid_1
);

  // Entry index is {warp, reg}, so the clear counter doubles as the
  // storage address: warp = counter / NUM_REGS, reg = counter % NUM_REGS.
  localparam int CW    = WW + AW;
  localparam int DEPTH = NUM_WARPS * NUM_REGS;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q;
  logic            rvalid_0_q, rvalid_0_d;
  logic            rvalid_1_q, rvalid_1_d;

  logic            idle_s;
  logic            clr_s;
  logic [CW-1:0]   wr_idx_s;
  logic [CW-1:0]   rd_idx_0_s;
  logic [CW-1:0]   rd_idx_1_s;
  logic            hit_0_s;
  logic            hit_1_s;

  assign idle_s     = (state_q == ST_IDLE);
  assign clr_s      = (state_q == ST_CLEAR);
  assign wr_idx_s   = {wr_warp, waddr};
  assign rd_idx_0_s = {rd_warp, raddr_0};
  assign rd_idx_1_s = {rd_warp, raddr_1};
  // Address match for the write-first bypass; qualified per lane below.
  assign hit_0_s    = (wr_warp == rd_warp) && (waddr == raddr_0);
  assign hit_1_s    = (wr_warp == rd_warp) && (waddr == raddr_1);

  // FSM state, clear counter and ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // FSM next state: sweep every entry once, then wait for init_req
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        // init_req is deliberately not looked at here: a clear in progress
        // is never restarted by it.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_CLEAR;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Read-valid next state: only an IDLE edge with any lane enabled
  always_comb begin
    rvalid_0_d = 1'b0;
    rvalid_1_d = 1'b0;
    if (idle_s) begin
      rvalid_0_d = |read_en_0;
      rvalid_1_d = |read_en_1;
    end else begin
      rvalid_0_d = 1'b0;
      rvalid_1_d = 1'b0;
    end
  end

  // Read-valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
    end else begin
      rvalid_0_q <= rvalid_0_d;
      rvalid_1_q <= rvalid_1_d;
    end
  end

  assign ready    = ready_q;
  assign rvalid_0 = rvalid_0_q;
  assign rvalid_1 = rvalid_1_q;

  // Each lane owns a private storage bank and private read registers, so
  // lane enables can never disturb a neighbouring lane.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] wlane_s;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;

    assign wlane_s = wdata[l*DATA_W +: DATA_W];

    // Storage bank: clear sweep has priority; intentionally not reset
    always_ff @(posedge clk) begin
      if (clr_s) begin
        mem_q[cnt_q] <= '0;
      end else if (write_en[l]) begin
        mem_q[wr_idx_s] <= wlane_s;
      end
    end

    // Port 0 lane data: hold, array read, or same-edge write bypass
    always_comb begin
      rd0_d = rd0_q;
      if (idle_s && read_en_0[l]) begin
        if (write_en[l] && hit_0_s) begin
          rd0_d = wlane_s;
        end else begin
          rd0_d = mem_q[rd_idx_0_s];
        end
      end else begin
        rd0_d = rd0_q;
      end
    end

    // Port 1 lane data: hold, array read, or same-edge write bypass
    always_comb begin
      rd1_d = rd1_q;
      if (idle_s && read_en_1[l]) begin
        if (write_en[l] && hit_1_s) begin
          rd1_d = wlane_s;
        end else begin
          rd1_d = mem_q[rd_idx_1_s];
        end
      end else begin
        rd1_d = rd1_q;
      end
    end

    // Registered read data for both ports
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd0_q <= '0;
        rd1_q <= '0;
      end else begin
        rd0_q <= rd0_d;
        rd1_q <= rd1_d;
      end
    end

    assign rdata_0[l*DATA_W +: DATA_W] = rd0_q;
    assign rdata_1[l*DATA_W +: DATA_W] = rd1_q;
  end

endmodule

// File: tb/tb_warp_register_file.sv
// ---------------------------------------------------------------------------
// tb_warp_register_file
//
// Directed plus randomized bench for warp_register_file at default
// parameters. A behavioural model (3-D array of register contents, a
// "clear cycles remaining" count, and expected read registers) predicts
// every output after each clock edge.
// ---------------------------------------------------------------------------
module tb_warp_register_file;

  localparam int NL    = 8;
  localparam int NW    = 8;
  localparam int NR    = 32;
  localparam int LW    = 64;
  localparam int DW    = NL * LW;
  localparam int DEPTH = NW * NR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_req;
  logic          ready;
  logic [2:0]    wr_warp;
  logic [NL-1:0] write_en;
  logic [4:0]    waddr;
  logic [DW-1:0] wdata;
  logic [2:0]    rd_warp;
  logic [NL-1:0] read_en_0;
  logic [NL-1:0] read_en_1;
  logic [4:0]    raddr_0;
  logic [4:0]    raddr_1;
  logic [DW-1:0] rdata_0;
  logic [DW-1:0] rdata_1;
  logic          rvalid_0;
  logic          rvalid_1;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [LW-1:0] mm [NW][NR][NL];
  logic [DW-1:0] e_rd0, e_rd1;
  logic          e_rv0, e_rv1;
  int            clear_left;

  logic [DW-1:0] pat;
  logic [DW-1:0] exp_v;
  bit            narrow;

  always #5 clk = ~clk;

  warp_register_file dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (init_req),
    .ready    (ready),
    .wr_warp  (wr_warp),
    .write_en (write_en),
    .waddr    (waddr),
    .wdata    (wdata),
    .rd_warp  (rd_warp),
    .read_en_0(read_en_0),
    .read_en_1(read_en_1),
    .raddr_0  (raddr_0),
    .raddr_1  (raddr_1),
    .rdata_0  (rdata_0),
    .rdata_1  (rdata_1),
    .rvalid_0 (rvalid_0),
    .rvalid_1 (rvalid_1)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    write_en  = '0;
    read_en_0 = '0;
    read_en_1 = '0;
    init_req  = 1'b0;
  endtask

  task automatic zero_model();
    for (int w = 0; w < NW; w++)
      for (int r = 0; r < NR; r++)
        for (int l = 0; l < NL; l++)
          mm[w][r][l] = '0;
  endtask

  // Outputs required while reset is (or has just been) asserted
  task automatic rst_checks(input string tag);
    chk({tag, "_ready"},  DW'(ready),    '0);
    chk({tag, "_rvalid0"}, DW'(rvalid_0), '0);
    chk({tag, "_rvalid1"}, DW'(rvalid_1), '0);
    chk({tag, "_rdata0"}, rdata_0, '0);
    chk({tag, "_rdata1"}, rdata_1, '0);
  endtask

  // Predict the effect of the current inputs, clock once, compare outputs
  task automatic cyc();
    logic [DW-1:0] n0, n1;
    logic          v0, v1;
    n0 = e_rd0;
    n1 = e_rd1;
    v0 = 1'b0;
    v1 = 1'b0;
    if (clear_left > 0) begin
      clear_left--;
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (read_en_0[l])
          n0[l*LW +: LW] = (write_en[l] && wr_warp == rd_warp && waddr == raddr_0)
                           ? wdata[l*LW +: LW] : mm[rd_warp][raddr_0][l];
        if (read_en_1[l])
          n1[l*LW +: LW] = (write_en[l] && wr_warp == rd_warp && waddr == raddr_1)
                           ? wdata[l*LW +: LW] : mm[rd_warp][raddr_1][l];
      end
      v0 = |read_en_0;
      v1 = |read_en_1;
      for (int l = 0; l < NL; l++)
        if (write_en[l]) mm[wr_warp][waddr][l] = wdata[l*LW +: LW];
      if (init_req) begin
        clear_left = DEPTH;
        zero_model();
      end
    end
    e_rd0 = n0;
    e_rd1 = n1;
    e_rv0 = v0;
    e_rv1 = v1;
    @(posedge clk);
    #1;
    chk("ready",   DW'(ready),    DW'(clear_left == 0));
    chk("rvalid0", DW'(rvalid_0), DW'(e_rv0));
    chk("rvalid1", DW'(rvalid_1), DW'(e_rv1));
    chk("rdata0",  rdata_0, e_rd0);
    chk("rdata1",  rdata_1, e_rd1);
  endtask

  task automatic read_all_zero();
    for (int w = 0; w < NW; w++)
      for (int r = 0; r < NR; r++) begin
        rd_warp = 3'(w); raddr_0 = 5'(r); raddr_1 = 5'(r);
        read_en_0 = 8'hFF; read_en_1 = 8'hFF;
        cyc();
        chk("all_zero0", rdata_0, '0);
        chk("all_zero1", rdata_1, '0);
      end
    quiet();
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    e_rd0 = '0; e_rd1 = '0; e_rv0 = 1'b0; e_rv1 = 1'b0;
    clear_left = DEPTH;
    zero_model();
    rst_checks(tag);
    repeat (2) begin
      @(posedge clk); #1;
      rst_checks({tag, "_hold"});
    end
    rst_n = 1'b1;
    repeat (DEPTH) cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    quiet();
    wr_warp = '0; rd_warp = '0; waddr = '0; raddr_0 = '0; raddr_1 = '0; wdata = '0;
    e_rd0 = '0; e_rd1 = '0; e_rv0 = 1'b0; e_rv1 = 1'b0;
    clear_left = DEPTH;
    zero_model();
    #1;
    rst_checks("por");
    repeat (3) begin
      @(posedge clk); #1;
      rst_checks("por_hold");
    end

    // Release: 256 clear cycles, then ready; whole file reads as zero
    rst_n = 1'b1;
    repeat (DEPTH) cyc();
    chk("ready_after_clear", DW'(ready), DW'(1'b1));
    read_all_zero();

    // Full-lane write, then read on both ports
    for (int l = 0; l < NL; l++) pat[l*LW +: LW] = 64'hA5A5_0000_0000_0000 + 64'(l);
    wr_warp = 3'd3; waddr = 5'd5; wdata = pat; write_en = 8'hFF;
    cyc(); quiet();
    rd_warp = 3'd3; raddr_0 = 5'd5; raddr_1 = 5'd5; read_en_0 = 8'hFF; read_en_1 = 8'hFF;
    cyc(); quiet();
    chk("w3r5_port0", rdata_0, pat);
    chk("w3r5_port1", rdata_1, pat);
    chk("w3r5_rvalid", DW'({rvalid_0, rvalid_1}), DW'(2'b11));

    // Same register in two warps
    wr_warp = 3'd2; waddr = 5'd7; wdata = {NL{64'h1111_1111_1111_1111}}; write_en = 8'hFF;
    cyc();
    wr_warp = 3'd5; wdata = {NL{64'h2222_2222_2222_2222}};
    cyc(); quiet();
    rd_warp = 3'd2; raddr_0 = 5'd7; read_en_0 = 8'hFF;
    cyc(); quiet();
    chk("warp2_r7", rdata_0, {NL{64'h1111_1111_1111_1111}});
    rd_warp = 3'd5; raddr_1 = 5'd7; read_en_1 = 8'hFF;
    cyc(); quiet();
    chk("warp5_r7", rdata_1, {NL{64'h2222_2222_2222_2222}});

    // Partial write with same-edge read: bypass on enabled lanes only
    wr_warp = 3'd1; waddr = 5'd4; wdata = {NL{64'hBEEF}}; write_en = 8'hFF;
    cyc();
    wdata = {NL{64'hCAFE}}; write_en = 8'h0F;
    rd_warp = 3'd1; raddr_1 = 5'd4; read_en_1 = 8'hFF;
    cyc(); quiet();
    chk("bypass_mix", rdata_1, {{4{64'hBEEF}}, {4{64'hCAFE}}});

    // Sparse lane read: only lanes 0 and 7 of port 0 update
    rd_warp = 3'd3; raddr_0 = 5'd5; read_en_0 = 8'hFF;
    cyc();
    rd_warp = 3'd1; raddr_0 = 5'd4; read_en_0 = 8'h81;
    cyc(); quiet();
    exp_v = pat;
    exp_v[0*LW +: LW] = 64'hCAFE;
    exp_v[7*LW +: LW] = 64'hBEEF;
    chk("sparse_read", rdata_0, exp_v);

    // Randomized traffic, biased toward address collisions
    for (int i = 0; i < 600; i++) begin
      narrow    = 1'($urandom_range(0, 1));
      wr_warp   = narrow ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      rd_warp   = narrow ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      waddr     = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      raddr_0   = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      raddr_1   = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      write_en  = 8'($urandom);
      read_en_0 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      read_en_1 = 8'($urandom);
      for (int l = 0; l < NL; l++) wdata[l*LW +: LW] = {$urandom, $urandom};
      init_req  = ($urandom_range(0, 199) == 0);
      cyc();
    end
    quiet();
    while (clear_left > 0) cyc();

    // init_req after writes; traffic during the clear is dropped
    wr_warp = 3'd6; waddr = 5'd9; wdata = {NL{64'h0123_4567_89AB_CDEF}}; write_en = 8'hFF;
    cyc(); quiet();
    rd_warp = 3'd6; raddr_0 = 5'd9; raddr_1 = 5'd9; read_en_0 = 8'hFF; read_en_1 = 8'hFF;
    cyc(); quiet();
    init_req = 1'b1;
    cyc();
    chk("init_ready_low", DW'(ready), '0);
    while (clear_left > 0) begin
      wr_warp   = 3'($urandom_range(0, 7));
      waddr     = 5'($urandom_range(0, 31));
      rd_warp   = 3'($urandom_range(0, 7));
      raddr_0   = 5'($urandom_range(0, 31));
      raddr_1   = 5'($urandom_range(0, 31));
      write_en  = 8'hFF;
      read_en_0 = 8'($urandom);
      read_en_1 = 8'($urandom);
      for (int l = 0; l < NL; l++) wdata[l*LW +: LW] = {$urandom, $urandom};
      init_req  = ($urandom_range(0, 15) == 0);
      cyc();
    end
    quiet();
    read_all_zero();

    // Reset pulse at clear cycle 100
    wr_warp = 3'd0; waddr = 5'd0; wdata = {NL{64'hFFFF_0000_FFFF_0000}}; write_en = 8'hFF;
    cyc(); quiet();
    rd_warp = 3'd0; raddr_0 = 5'd0; raddr_1 = 5'd0; read_en_0 = 8'hFF; read_en_1 = 8'hFF;
    cyc(); quiet();
    init_req = 1'b1;
    cyc(); quiet();
    repeat (99) cyc();
    apply_reset("rst_mid_clear");
    chk("ready_after_rst_clear", DW'(ready), DW'(1'b1));
    rd_warp = 3'd0; raddr_0 = 5'd0; read_en_0 = 8'hFF;
    cyc(); quiet();
    chk("w0r0_zero_after_rst", rdata_0, '0);

    // Reset pulse while idle with live read data
    wr_warp = 3'd7; waddr = 5'd31; wdata = {NL{64'h5A5A_5A5A_5A5A_5A5A}}; write_en = 8'hFF;
    cyc(); quiet();
    rd_warp = 3'd7; raddr_0 = 5'd31; raddr_1 = 5'd31; read_en_0 = 8'hFF; read_en_1 = 8'hFF;
    cyc(); quiet();
    apply_reset("rst_mid_idle");
    read_all_zero();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_register_file.md
WARP_REGISTER_FILE -- requirements
Module: warp_register_file

Interface
REQ-001 SHALL provide parameter NUM_LANES, default 8, number of SIMD lanes.
REQ-002 SHALL provide parameter NUM_WARPS, default 8, number of warp contexts; power of 2, at least 2.
REQ-003 SHALL provide parameter NUM_REGS, default 32, registers per warp per lane; power of 2, at least 2.
REQ-004 SHALL provide parameter DATA_W, default 64, register width in bits.
REQ-005 Ports (WW = log2(NUM_WARPS), AW = log2(NUM_REGS), DW = NUM_LANES*DATA_W; lane l occupies bits [l*DATA_W +: DATA_W]):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- init_req  in  1  request to re-clear the whole file.
- ready  out  1  high when the file accepts reads and writes.
- wr_warp  in  WW  warp targeted by the write.
- write_en  in  NUM_LANES  per-lane write enable.
- waddr  in  AW  write register address.
- wdata  in  DW  write data, all lanes.
- rd_warp  in  WW  warp targeted by both read ports.
- read_en_0 / read_en_1  in  NUM_LANES  per-lane read enable, port 0 / port 1.
- raddr_0 / raddr_1  in  AW  read register address, port 0 / port 1.
- rdata_0 / rdata_1  out  DW  registered read data, port 0 / port 1.
- rvalid_0 / rvalid_1  out  1  read data valid, port 0 / port 1.

Function
REQ-006 SHALL hold NUM_WARPS x NUM_REGS x NUM_LANES entries of DATA_W bits; the storage array itself SHALL NOT be reset by rst_n.
REQ-007 SHALL implement a two-state FSM: CLEAR and IDLE; ready = 1 only in IDLE.
REQ-008 In CLEAR, each cycle SHALL zero all lanes of one entry indexed by a clear counter (warp = counter / NUM_REGS, reg = counter % NUM_REGS), then increment the counter.
REQ-009 CLEAR SHALL transition to IDLE after the entry at counter NUM_WARPS*NUM_REGS-1 is zeroed, so CLEAR lasts exactly NUM_WARPS*NUM_REGS cycles.
REQ-010 In IDLE, init_req = 1 SHALL move the FSM to CLEAR on the next edge with the counter at 0; init_req during CLEAR SHALL be ignored and SHALL NOT restart the count.
REQ-011 In CLEAR, write_en SHALL be ignored, and read enables SHALL be ignored (rvalid_p = 0, rdata_p holds its value).
REQ-012 In IDLE, on each edge, every lane l with write_en[l] = 1 SHALL store wdata lane l at (wr_warp, waddr, l); lanes with write_en[l] = 0 SHALL be unchanged.
REQ-013 Reads SHALL have 1-cycle latency: inputs sampled at edge N, data and valid presented after edge N.
REQ-014 For port p at a sampled edge in IDLE: each lane with read_en_p[l] = 1 SHALL load entry (rd_warp, raddr_p, l) into rdata_p; lanes with read_en_p[l] = 0 SHALL hold their previous rdata_p value.
REQ-015 rvalid_p SHALL be 1 for the cycle after an IDLE edge where read_en_p is non-zero, and 0 otherwise.
REQ-016 Write-first bypass: if, at the same edge, wr_warp = rd_warp, waddr = raddr_p, write_en[l] = 1 and read_en_p[l] = 1, then lane l of rdata_p SHALL return the new wdata.
REQ-017 Both ports reading the same entry in the same cycle SHALL return identical data; ports SHALL be fully independent otherwise.
REQ-018 Lanes SHALL be independent: no lane's enable SHALL affect another lane's storage or read data.

Reset
REQ-019 While rst_n = 0, outputs SHALL be: ready = 0, rvalid_0 = rvalid_1 = 0, rdata_0 = rdata_1 = 0.
REQ-020 While rst_n = 0, the FSM SHALL be in CLEAR with the counter at 0; CLEAR SHALL begin at the first edge after deassertion.
REQ-021 Assertion of rst_n mid-CLEAR or mid-IDLE SHALL take effect immediately (asynchronous), and the full clear SHALL restart from counter 0.

Verification (default parameters)
REQ-022 Release reset -> ready = 0 for exactly 256 cycles, then 1; read all 8 warps x 32 regs with read_en = 8'hFF -> every lane returns 0, with rvalid = 1.
REQ-023 Write wr_warp = 3, waddr = 5, write_en = 8'hFF, lane l = 64'hA5A5_0000_0000_0000 + l; read next cycle on both ports -> rdata_0 and rdata_1 lanes match, rvalid_0 and rvalid_1 = 1 one cycle after the read.
REQ-024 Write warp 2 reg 7 = 64'h1111_1111_1111_1111 and warp 5 reg 7 = 64'h2222_2222_2222_2222 on all lanes; read each -> no cross-warp corruption.
REQ-025 Warp 1 reg 4 holds 64'hBEEF on all lanes; in the same cycle write 64'hCAFE with write_en = 8'h0F and read port 1 with read_en_1 = 8'hFF -> lanes 0-3 return 64'hCAFE, lanes 4-7 return 64'hBEEF.
REQ-026 Port 0 reads with read_en_0 = 8'h81 -> only lanes 0 and 7 update, other lanes hold their prior value.
REQ-027 init_req after writes, with writes issued during CLEAR -> ready low for 256 cycles, writes are dropped, all reads return 0; rst_n pulsed at CLEAR cycle 100 -> outputs 0 immediately and ready rises 256 cycles after release.
